alu_b_operand_stage: RTL
========================

ALU_B_OPERAND_STAGE -- requirements
Module: alu_b_operand_stage

Interface
- REQ-001: Parameter WIDTH, default 32, operand width in bits (legal range 8..64).
- REQ-002: Parameter CONST_VAL, default 4, constant operand (PC increment), truncated to WIDTH.
- REQ-003: Parameter ERR_CNT_W, default 8, width of the illegal-select counter.
- REQ-004: clk  in  1  single clock, all state on rising edge.
- REQ-005: reset_n  in  1  asynchronous, active-low reset.
- REQ-006: sel  in  3  operand select, sampled with in_valid.
- REQ-007: data_0, data_2, data_3  in  WIDTH each  source operands (register B, immediate, shifted immediate).
- REQ-008: in_valid / in_ready  in / out  1 each  upstream handshake.
- REQ-009: data_out  out  WIDTH  selected operand.
- REQ-010: out_valid / out_ready  out / in  1 each  downstream handshake.
- REQ-011: sel_err  out  1  sticky flag, set on any accepted illegal sel.
- REQ-012: err_cnt  out  ERR_CNT_W  saturating count of accepted illegal sels.

Function
- REQ-013: Transfer occurs on an edge where valid && ready on that side; no other event moves data.
- REQ-014: Select map: 0 -> data_0; 1 -> CONST_VAL; 2 -> data_2; 3 -> data_3; 4 -> ~data_0; 5 -> (~data_0 + 1) mod 2^WIDTH (macro only, REQ-026); others illegal.
- REQ-015: Illegal sel is accepted normally, yields CONST_VAL, sets sel_err, and increments err_cnt, saturating at all-ones.
- REQ-016: Operand is computed from sel/data at the accept edge; later input changes do not alter stored entries.
- REQ-017: Latency: accepted operand appears on data_out with out_valid at earliest the next cycle.
- REQ-018: Two-entry skid buffer; states EMPTY, ONE, FULL.
- REQ-019: EMPTY: accept -> ONE.
- REQ-020: ONE: accept without drain -> FULL; drain without accept -> EMPTY; both -> ONE.
- REQ-021: FULL: drain -> ONE; in_ready = 0, so no accept is possible.
- REQ-022: in_ready = 1 in EMPTY and ONE, registered (no combinational path from out_ready).
- REQ-023: out_valid = 1 in ONE and FULL; data_out is the oldest entry and holds stable while out_valid && !out_ready.
- REQ-024: Throughput: one operand per cycle sustained when out_ready is held high; order strictly FIFO.

Reset
- REQ-025: reset_n low asynchronously forces EMPTY, out_valid = 0, in_ready = 0 during reset (1 from first edge after release), data_out = 0, sel_err = 0, err_cnt = 0; buffered entries are discarded mid-operation.

Configuration
- REQ-026: Macro ALU_B_NEG_EN: defined -> sel 5 yields two's-complement negation of data_0; undefined -> sel 5 is illegal per REQ-015 and the negation adder is absent.

Structure
- REQ-027: Package alu_b_pkg holds select code localparams (SEL_B, SEL_CONST, SEL_IMM, SEL_SHIMM, SEL_NOTB, SEL_NEGB) and buffer state encoding.
- REQ-028: Sub-module alu_b_skid (WIDTH-parameterised two-entry skid buffer with handshake); operand decode and error counter stay in the top.

Verification
- REQ-029: Reset, then sel 0..4 with data_0 = 0x0000_00F0, data_2 = 0x1234, data_3 = 0x48D0, out_ready = 1 -> outputs 0xF0, 0x4, 0x1234, 0x48D0, 0xFFFF_FF0F in order, one per cycle.
- REQ-030: out_ready = 0, three back-to-back offers -> two accepted, in_ready low in FULL, third held; raise out_ready -> all three delivered in order, data_out stable while stalled.
- REQ-031: sel 6, then sel 7 -> data_out 0x4 both, sel_err = 1, err_cnt = 2; 300 illegal accepts with ERR_CNT_W = 8 -> err_cnt = 255.
- REQ-032: sel 5, data_0 = 0x0000_0001 -> 0xFFFF_FFFF with ALU_B_NEG_EN; without it -> 0x4, sel_err = 1.
- REQ-033: reset_n pulsed low while FULL -> out_valid drops immediately, err_cnt = 0, no stale entry emitted after release.
- REQ-034: WIDTH = 16, CONST_VAL = 2, sel 4 with data_0 = 0x00FF -> 0xFF00; sel 1 -> 0x0002.

Source files
------------

// File: rtl/alu_b_pkg.sv
// Shared select codes and skid-buffer state encoding for the ALU B-operand stage.
package alu_b_pkg;

    localparam logic [2:0] SEL_B     = 3'd0;
    localparam logic [2:0] SEL_CONST = 3'd1;
    localparam logic [2:0] SEL_IMM   = 3'd2;
    localparam logic [2:0] SEL_SHIMM = 3'd3;
    localparam logic [2:0] SEL_NOTB  = 3'd4;
    localparam logic [2:0] SEL_NEGB  = 3'd5;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_b_skid.sv
// Two-entry skid buffer with valid/ready handshakes on both sides.
// in_ready is a flop, so it has no combinational path from out_ready.
module alu_b_skid
    import alu_b_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       state_q;
    buf_state_t       state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             ready_q;
    logic             accept;
    logic             drain;
    logic             load_head;
    logic             load_tail;
    logic             head_from_tail;

    assign out_valid = (state_q != BUF_EMPTY);
    assign in_ready  = ready_q;
    assign out_data  = head_q;
    assign accept    = in_valid && ready_q;
    assign drain     = out_valid && out_ready;

    // The head slot always holds the oldest entry; the tail only fills when the head is stalled.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    state_d   = BUF_ONE;
                    load_head = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && drain) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_d   = BUF_FULL;
                    load_tail = 1'b1;
                end else if (drain) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (drain) begin
                    state_d        = BUF_ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BUF_EMPTY;
            ready_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != BUF_FULL);
            if (load_head) begin
                head_q <= in_data;
            end else if (head_from_tail) begin
                head_q <= tail_q;
            end
            if (load_tail) begin
                tail_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_b_operand_stage.sv
// ALU B-operand select stage: decodes sel into an operand, buffers it in a skid buffer, counts illegal selects.
// Define ALU_B_NEG_EN to enable sel 5 (two's-complement negation of data_0); otherwise sel 5 is illegal.
module alu_b_operand_stage
    import alu_b_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int unsigned CONST_VAL = 4,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     data_0,
    input  logic [WIDTH-1:0]     data_2,
    input  logic [WIDTH-1:0]     data_3,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

    logic [WIDTH-1:0] operand;
    logic             illegal;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Illegal selects still produce a defined operand so the pipeline never stalls on them.
    always_comb begin
        operand = CONST_W;
        illegal = 1'b0;
        case (sel)
            SEL_B:     operand = data_0;
            SEL_CONST: operand = CONST_W;
            SEL_IMM:   operand = data_2;
            SEL_SHIMM: operand = data_3;
            SEL_NOTB:  operand = ~data_0;
`ifdef ALU_B_NEG_EN
            SEL_NEGB:  operand = ~data_0 + WIDTH'(1);
`endif
            default:   illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (accept && illegal) begin
            sel_err <= 1'b1;
            if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    alu_b_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (data_out)
    );

endmodule
